mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer between the CPU datapath and the byte-addressed data RAM. It latches one load/store request and drives the RAM's write-enable, instruction, address and write-data inputs for one cycle. It then returns the RAM's registered read data with a completion pulse. While the access is in flight it holds the CPU with a stall signal, and it suppresses misaligned accesses, reporting them as faults instead.

## Interface
- ADDR_W, 11, RAM byte-address width
- XLEN, 64, data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  CPU presents a memory instruction
- req_inst  in  32  instruction word (opcode [6:0], funct3 [14:12])
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data (rs2)
- req_ready  out  1  controller can accept a request
- stall  out  1  CPU must hold PC/pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  load result (already extended by RAM)
- resp_misalign  out  1  with resp_valid: access suppressed, misaligned
- ram_we  out  1  RAM write enable
- ram_inst  out  32  instruction forwarded to RAM
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  XLEN  RAM write data
- ram_rdata  in  XLEN  RAM registered read data

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch inst, addr[ADDR_W-1:0], wdata, and the computed misalign flag; go to ISSUE.
  - Upper address bits are discarded (no range fault).
- ISSUE:
  - ram_inst, ram_addr, ram_wdata come from the latches.
  - ram_we=1 only if opcode==0100011, not misaligned, and rst=0.
  - RAM samples at the end of ISSUE; next state is RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata=ram_rdata if opcode==0000011, not misaligned; else 0.
  - resp_misalign is the latched flag.
  - Next state is IDLE unconditionally.
  - req_ready=0, so the still-asserted req_valid of the same instruction is never re-accepted.
- Misalign rule, by funct3[1:0]:
  - 00 (b/bu): always aligned.
  - 01 (h/hu): addr[0]==0.
  - 10 (w/wu): addr[1:0]==0.
  - 11 (d): addr[2:0]==0.
  - A misaligned store writes nothing; a misaligned load returns 0.
- Non-load/store opcode with req_valid:
  - Accepted and sequenced identically; ram_we=0, resp_rdata=0, resp_misalign=0.
- stall = req_valid & ~resp_valid (combinational). The CPU advances exactly in the RESP cycle.
- In IDLE and RESP: ram_we=0, ram_inst=0, ram_addr=0, ram_wdata=0.
  - ram_inst=0 gives funct3=000, so RAM read activity is harmless.

## Timing
- Reset (rst high at an edge):
  - State becomes IDLE.
  - All latches clear to 0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_misalign=0, ram_we=0, ram_inst/addr/wdata=0.
  - stall follows req_valid.
- Latency: request accepted at edge E0. ISSUE runs between E0 and E1; RESP runs between E1 and E2. Total 2 cycles; stall is high for cycle 0 and ISSUE, low in RESP.
- Back-to-back: new req_valid in the cycle after RESP (IDLE) is accepted. Sustained throughput is one access per 3 cycles.
- Store data is visible to a load accepted after that store's RESP. No forwarding is needed, since the write lands at E1.
- rst during ISSUE:
  - ram_we is forced 0 in that cycle, so no partial write.
  - Next state is IDLE and no resp_valid is produced.
- rst during RESP: resp_valid is still high in that cycle (combinational from state), then IDLE.
- req_inst, req_addr and req_wdata changes after acceptance are ignored.

## Test plan
- Reset, then sd 0x1122334455667788 to addr 0x010:
  - ram_we=1 only in ISSUE, with ram_addr=0x010.
  - resp_valid one cycle later, resp_misalign=0.
  - stall high for exactly 2 cycles.
- Same sd, then ld from 0x010 → resp_rdata=0x1122334455667788. Then lb from 0x017 → 0xFFFFFFFFFFFFFF88.
- sw to 0x102 (misaligned) → ram_we never 1, resp_misalign=1. A following lw from 0x100 returns the prior contents unchanged.
- Non-memory opcode 0x00000013 with req_valid → ram_we=0, resp_valid after 2 cycles, resp_rdata=0, resp_misalign=0.
- Assert rst during ISSUE of an sd to 0x020 → ram_we=0 that cycle, no resp_valid. A later ld from 0x020 returns 0 (fresh RAM).
- Hold req_valid continuously across four sb instructions (addresses 0x000–0x003) → exactly four resp_valid pulses, spaced 3 cycles apart, with no duplicate writes.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences a single CPU load/store into the byte-addressed
// data RAM. Flow: IDLE accepts the request, ISSUE drives the RAM for one
// cycle, and RESP returns the RAM's registered read data with a one-cycle
// completion pulse. A misaligned access never reaches the RAM. It completes
// with resp_misalign set and zero read data.
module mem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_inst,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misalign,
  output logic              ram_we,
  output logic [31:0]       ram_inst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         inst_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic                misalign_q;

  logic                req_is_mem;
  logic                req_misalign;
  logic                is_load_q;
  logic                is_store_q;

  // The RAM only sees the low ADDR_W address bits. The rest are dropped
  // silently, and no range fault is raised.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W];

  assign req_is_mem = (req_inst[6:0] == OP_LOAD) || (req_inst[6:0] == OP_STORE);
  assign is_load_q  = (inst_q[6:0] == OP_LOAD);
  assign is_store_q = (inst_q[6:0] == OP_STORE);

  // Misalignment check for the incoming request. The access size comes from
  // funct3[1:0]. Only a load or store can be misaligned.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req_misalign = 1'b0;
    unique case (req_inst[13:12])
      2'b00: req_misalign = 1'b0;
      2'b01: req_misalign = req_addr[0];
      2'b10: req_misalign = |req_addr[1:0];
      2'b11: req_misalign = |req_addr[2:0];
      default: req_misalign = 1'b0;
    endcase
    if (!req_is_mem) req_misalign = 1'b0;
  end

  // Request FSM. Accept in IDLE, drive the RAM in ISSUE, complete in RESP.
  // A synchronous reset returns the FSM to IDLE and clears the latches.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // in this block sees the values from before the edge.
    if (rst) begin
      state      <= IDLE;
      inst_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            inst_q     <= req_inst;
            addr_q     <= req_addr[ADDR_W-1:0];
            wdata_q    <= req_wdata;
            misalign_q <= req_misalign;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state. The RAM bus is zero outside ISSUE, so the RAM
  // sees funct3=000 and its reads stay harmless. ram_we also depends on rst,
  // which blocks a partial write during a reset cycle.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_misalign = 1'b0;
    ram_we        = 1'b0;
    ram_inst      = '0;
    ram_addr      = '0;
    ram_wdata     = '0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      ISSUE: begin
        ram_inst  = inst_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_we    = is_store_q && !misalign_q && !rst;
      end
      RESP: begin
        resp_valid    = 1'b1;
        resp_misalign = misalign_q;
        if (is_load_q && !misalign_q) resp_rdata = ram_rdata;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Stall drops in the RESP cycle, so the CPU advances exactly then.
  assign stall = req_valid & ~resp_valid;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. It contains a behavioural big-endian data
// RAM with registered, extended read data. A scoreboard queue holds the
// expected completion of each request.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 11;
  localparam int XLEN   = 64;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [31:0]       req_inst;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misalign;
  logic              ram_we;
  logic [31:0]       ram_inst;
  logic [ADDR_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   ram_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_inst     (req_inst),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_misalign(resp_misalign),
    .ram_we       (ram_we),
    .ram_inst     (ram_inst),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Big-endian byte RAM. It samples at the clock edge. Read data is
  // registered and extended according to funct3.
  bit [7:0] mem [2048];
  always @(posedge clk) begin : ram_model
    logic [63:0] v;
    int          n;
    n = 1 << ram_inst[13:12];
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(mem[11'(int'(ram_addr) + i)]);
    if (!ram_inst[14]) begin
      case (n)
        1: v = {{56{v[7]}},  v[7:0]};
        2: v = {{48{v[15]}}, v[15:0]};
        4: v = {{32{v[31]}}, v[31:0]};
        default: v = v;
      endcase
    end
    ram_rdata <= v;
    if (ram_we)
      for (int i = 0; i < n; i++) mem[11'(int'(ram_addr) + i)] <= ram_wdata[8*(n-1-i) +: 8];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, resp_rdata, e.rdata);
      check({tag, " misalign"}, 64'(resp_misalign), 64'(e.mis));
    end
  endtask

  // One request with full checking. The task is entered just after a rising
  // edge with the DUT in IDLE. After acceptance the request inputs are
  // scrambled, and the DUT must ignore them.
  task automatic do_req(input string tag, input logic [31:0] inst, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_mis, input logic exp_we);
    int stalls = 0;
    int wes    = 0;
    int cyc    = 0;
    bit done   = 0;
    sb.push_back('{exp_rdata, exp_mis});
    req_valid = 1'b1;
    req_inst  = inst;
    req_addr  = addr;
    req_wdata = wdata;
    while (!done && cyc < 8) begin
      @(negedge clk);
      if (stall) stalls++;
      if (ram_we) wes++;
      if (cyc == 0) check({tag, " ready_idle"}, 64'(req_ready), 64'd1);
      if (cyc == 1) begin
        check({tag, " ram_we"},    64'(ram_we), 64'(exp_we));
        check({tag, " ram_addr"},  64'(ram_addr), 64'(addr[ADDR_W-1:0]));
        check({tag, " ram_inst"},  64'(ram_inst), 64'(inst));
        check({tag, " ram_wdata"}, ram_wdata, wdata);
      end
      if (resp_valid) begin
        done = 1;
        pop_check(tag);
        check({tag, " latency"},   64'(cyc), 64'd2);
        check({tag, " ready_resp"}, 64'(req_ready), 64'd0);
        check({tag, " ram_inst_resp"}, 64'(ram_inst), 64'd0);
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        req_inst  = ~inst;
        req_addr  = ~addr;
        req_wdata = ~wdata;
      end
      cyc++;
    end
    req_valid = 1'b0;
    req_inst  = '0;
    req_addr  = '0;
    req_wdata = '0;
    check({tag, " completed"}, 64'(done), 64'd1);
    check({tag, " stall_cycles"}, 64'(stalls), 64'd2);
    check({tag, " we_pulses"}, 64'(wes), 64'(exp_we));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_inst  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state. stall follows req_valid, and nothing is accepted during reset.
    @(negedge clk);
    check("rst req_ready",  64'(req_ready), 64'd1);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_rdata", resp_rdata, 64'd0);
    check("rst misalign",   64'(resp_misalign), 64'd0);
    check("rst ram_we",     64'(ram_we), 64'd0);
    check("rst ram_inst",   64'(ram_inst), 64'd0);
    check("rst ram_addr",   64'(ram_addr), 64'd0);
    check("rst ram_wdata",  ram_wdata, 64'd0);
    check("rst stall0",     64'(stall), 64'd0);
    req_valid = 1'b1;
    req_inst  = mk(OP_STORE, 3'b011);
    #1;
    check("rst stall1", 64'(stall), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("rst not_accepted", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Store, then load back the doubleword, then a sign-extended byte.
    do_req("sd_010", mk(OP_STORE, 3'b011), 64'h010, 64'h1122334455667788, 64'd0, 1'b0, 1'b1);
    do_req("ld_010", mk(OP_LOAD, 3'b011),  64'h010, 64'h0, 64'h1122334455667788, 1'b0, 1'b0);
    do_req("lb_017", mk(OP_LOAD, 3'b000),  64'h017, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 1'b0);
    do_req("lhu_016", mk(OP_LOAD, 3'b101), 64'h016, 64'h0, 64'h0000000000007788, 1'b0, 1'b0);
    do_req("lh_011_mis", mk(OP_LOAD, 3'b001), 64'h011, 64'h0, 64'd0, 1'b1, 1'b0);

    // A misaligned store writes nothing.
    do_req("sw_100", mk(OP_STORE, 3'b010), 64'h100, 64'hDEADBEEF, 64'd0, 1'b0, 1'b1);
    do_req("sw_102_mis", mk(OP_STORE, 3'b010), 64'h102, 64'h55555555, 64'd0, 1'b1, 1'b0);
    do_req("lw_100", mk(OP_LOAD, 3'b010), 64'h100, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0, 1'b0);
    do_req("lw_102_mis", mk(OP_LOAD, 3'b010), 64'h102, 64'h0, 64'd0, 1'b1, 1'b0);

    // Non-memory opcodes are sequenced the same way, with no side effects.
    // High address bits are dropped.
    do_req("addi", 32'h00000013, 64'h010, 64'h0, 64'd0, 1'b0, 1'b0);
    do_req("op_f3_011", 32'h00003013, 64'h011, 64'h0, 64'd0, 1'b0, 1'b0);
    do_req("ld_hi_addr", mk(OP_LOAD, 3'b011), 64'hABCD_0000_0000_0010, 64'h0,
           64'h1122334455667788, 1'b0, 1'b0);

    // Reset during ISSUE: no write and no response.
    req_valid = 1'b1;
    req_inst  = mk(OP_STORE, 3'b011);
    req_addr  = 64'h020;
    req_wdata = 64'hCAFEF00DCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_issue ram_we", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_issue no_resp", 64'(resp_valid), 64'd0);
      check("rst_issue ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end
    do_req("ld_020", mk(OP_LOAD, 3'b011), 64'h020, 64'h0, 64'd0, 1'b0, 1'b0);

    // Reset during RESP: the pulse in that cycle still appears.
    req_valid = 1'b1;
    req_inst  = mk(OP_LOAD, 3'b100);
    req_addr  = 64'h010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp valid", 64'(resp_valid), 64'd1);
    check("rst_resp rdata", resp_rdata, 64'h11);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_resp idle_valid", 64'(resp_valid), 64'd0);
    check("rst_resp idle_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // req_valid held across four sb requests. Each response is
    // 3 cycles after the previous one, with exactly one write per request.
    begin : back_to_back
      int resp_cyc[$];
      int wes    = 0;
      int n_resp = 0;
      int idx    = 0;
      bit seen;
      for (int k = 0; k < 4; k++) sb.push_back('{64'd0, 1'b0});
      req_valid = 1'b1;
      req_inst  = mk(OP_STORE, 3'b000);
      req_addr  = 64'h000;
      req_wdata = 64'hA0;
      for (int c = 0; c < 24 && n_resp < 4; c++) begin
        @(negedge clk);
        seen = resp_valid;
        if (ram_we) wes++;
        if (resp_valid) begin
          pop_check("b2b");
          resp_cyc.push_back(c);
          n_resp++;
        end
        @(posedge clk); #1;
        if (seen && idx < 3) begin
          idx++;
          req_addr  = 64'(idx);
          req_wdata = 64'hA0 + 64'(idx);
        end
      end
      req_valid = 1'b0;
      check("b2b resp_count", 64'(n_resp), 64'd4);
      check("b2b we_count", 64'(wes), 64'd4);
      if (resp_cyc.size() == 4)
        for (int k = 0; k < 3; k++)
          check("b2b spacing", 64'(resp_cyc[k+1] - resp_cyc[k]), 64'd3);
    end
    do_req("lw_000", mk(OP_LOAD, 3'b010), 64'h000, 64'h0, 64'hFFFFFFFFA0A1A2A3, 1'b0, 1'b0);

    check("sb drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
